// File: rtl/pls_pkg.sv
// rtl/pls_pkg.sv - shared TX state type and default 10BASE-T timing values
package pls_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_ETD,
        ST_SILENCE,
        ST_JAB
    } tx_state_e;

    // Timing in 50 ns half-bit cycles of clk_20mhz
    localparam int PLS_NLP_INTERVAL     = 320000;
    localparam int PLS_LP_WIDTH         = 2;
    localparam int PLS_ETD_CYCLES       = 12;
    localparam int PLS_SILENCE_CYCLES   = 48;
    localparam int PLS_JABBER_CYCLES    = 400000;
    localparam int PLS_UNJAB_CYCLES     = 10000;
    localparam int PLS_LP_MIN_GAP       = 80000;
    localparam int PLS_LP_MAX_GAP       = 500000;
    localparam int PLS_LINK_PULSES      = 3;
    localparam int PLS_LINK_FAIL_CYCLES = 2000000;

endpackage

// File: rtl/pls_link_mon.sv
// rtl/pls_link_mon.sv - receive pair synchroniser and link-integrity monitor
module pls_link_mon import pls_pkg::*; #(
    parameter int LP_MIN_GAP       = PLS_LP_MIN_GAP,
    parameter int LP_MAX_GAP       = PLS_LP_MAX_GAP,
    parameter int LINK_PULSES      = PLS_LINK_PULSES,
    parameter int LINK_FAIL_CYCLES = PLS_LINK_FAIL_CYCLES
) (
    input  logic clk_20mhz,
    input  logic rst_i,
    input  logic rxd_in_p,
    input  logic rxd_in_n,
    output logic rxd_out,
    output logic link_ok
);

    localparam int GW = $clog2(LINK_FAIL_CYCLES + 1);
    localparam int CW = $clog2(LINK_PULSES + 1);

    logic          p_meta, p_sync, n_meta, n_sync;
    logic          started;
    logic [GW-1:0] gap;
    logic [CW-1:0] pulses;
    logic          rx_next, rise;
    logic [GW-1:0] gap_meas;

    assign rx_next  = p_sync & ~n_sync;
    assign rise     = rx_next & ~rxd_out;
    // gap_meas is the edge-to-edge distance; started clears before gap can reach its maximum
    assign gap_meas = gap + 1'b1;

    always_ff @(posedge clk_20mhz or posedge rst_i) begin
        if (rst_i) begin
            p_meta  <= 1'b0;
            p_sync  <= 1'b0;
            n_meta  <= 1'b0;
            n_sync  <= 1'b0;
            rxd_out <= 1'b0;
            started <= 1'b0;
            gap     <= '0;
            pulses  <= '0;
            link_ok <= 1'b0;
        end else begin
            p_meta  <= rxd_in_p;
            p_sync  <= p_meta;
            n_meta  <= rxd_in_n;
            n_sync  <= n_meta;
            rxd_out <= rx_next;
            if (rise) begin
                gap     <= '0;
                started <= 1'b1;
                if (started) begin
                    if (gap_meas >= GW'(LP_MIN_GAP) && gap_meas <= GW'(LP_MAX_GAP)) begin
                        if (pulses >= CW'(LINK_PULSES - 1)) begin
                            pulses  <= CW'(LINK_PULSES);
                            link_ok <= 1'b1;
                        end else begin
                            pulses <= pulses + 1'b1;
                        end
                    end else if (gap_meas > GW'(LP_MAX_GAP)) begin
                        pulses <= CW'(1);
                    end
                end
            end else if (started) begin
                gap <= gap_meas;
                if (gap_meas == GW'(LINK_FAIL_CYCLES)) begin
                    link_ok <= 1'b0;
                    pulses  <= '0;
                    started <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/pls_gen2.sv
// rtl/pls_gen2.sv - 10BASE-T PLS: Manchester TX with ETD, silence, NLP and jabber, plus RX link monitor
module pls_gen2 import pls_pkg::*; #(
    parameter int NLP_INTERVAL     = PLS_NLP_INTERVAL,
    parameter int LP_WIDTH         = PLS_LP_WIDTH,
    parameter int ETD_CYCLES       = PLS_ETD_CYCLES,
    parameter int SILENCE_CYCLES   = PLS_SILENCE_CYCLES,
    parameter int JABBER_CYCLES    = PLS_JABBER_CYCLES,
    parameter int UNJAB_CYCLES     = PLS_UNJAB_CYCLES,
    parameter int LP_MIN_GAP       = PLS_LP_MIN_GAP,
    parameter int LP_MAX_GAP       = PLS_LP_MAX_GAP,
    parameter int LINK_PULSES      = PLS_LINK_PULSES,
    parameter int LINK_FAIL_CYCLES = PLS_LINK_FAIL_CYCLES
) (
    input  logic clk_20mhz,
    input  logic rst_i,
    input  logic data_enable,
    input  logic txd_in,
    input  logic nlp_en,
    input  logic rxd_in_p,
    input  logic rxd_in_n,
    output logic rxd_out,
    output logic txd_out_p,
    output logic txd_out_n,
    output logic txbusy,
    output logic jabber,
    output logic link_ok
);

    localparam int NW = $clog2(NLP_INTERVAL + 1);
    localparam int LW = $clog2(LP_WIDTH + 1);
    localparam int EW = $clog2(ETD_CYCLES + 1);
    localparam int SW = $clog2(SILENCE_CYCLES + 1);
    localparam int JW = $clog2(JABBER_CYCLES + 1);
    localparam int UW = $clog2(UNJAB_CYCLES + 1);

    tx_state_e     state;
    logic          phase, bit_q, nlp_pend;
    logic [NW-1:0] nlp_cnt;
    logic [LW-1:0] lp_cnt;
    logic [EW-1:0] etd_cnt;
    logic [SW-1:0] sil_cnt;
    logic [JW-1:0] jab_cnt;
    logic [UW-1:0] quiet_cnt;
    logic          nlp_fire;

    assign nlp_fire = (nlp_cnt == NW'(NLP_INTERVAL - 1));

    always_ff @(posedge clk_20mhz or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            phase     <= 1'b0;
            bit_q     <= 1'b0;
            nlp_pend  <= 1'b0;
            nlp_cnt   <= '0;
            lp_cnt    <= '0;
            etd_cnt   <= '0;
            sil_cnt   <= '0;
            jab_cnt   <= '0;
            quiet_cnt <= '0;
            txd_out_p <= 1'b0;
            txd_out_n <= 1'b0;
            txbusy    <= 1'b0;
            jabber    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (data_enable) begin
                        state     <= ST_DATA;
                        phase     <= 1'b0;
                        bit_q     <= txd_in;
                        nlp_cnt   <= '0;
                        nlp_pend  <= 1'b0;
                        lp_cnt    <= '0;
                        jab_cnt   <= '0;
                        txd_out_p <= ~txd_in;
                        txd_out_n <= txd_in;
                        txbusy    <= 1'b1;
                    end else begin
                        nlp_cnt   <= nlp_fire ? '0 : nlp_cnt + 1'b1;
                        txd_out_n <= 1'b0;
                        // A pulse still runs its length with nlp_en low, it just stays off the line
                        if (nlp_fire || nlp_pend) begin
                            nlp_pend  <= 1'b0;
                            txd_out_p <= nlp_en;
                            lp_cnt    <= LW'(LP_WIDTH - 1);
                        end else if (lp_cnt != '0) begin
                            lp_cnt <= lp_cnt - 1'b1;
                        end else begin
                            txd_out_p <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (jab_cnt == JW'(JABBER_CYCLES - 1)) begin
                        state     <= ST_JAB;
                        quiet_cnt <= '0;
                        txd_out_p <= 1'b0;
                        txd_out_n <= 1'b0;
                        jabber    <= 1'b1;
                    end else begin
                        jab_cnt <= jab_cnt + 1'b1;
                        if (!phase) begin
                            phase     <= 1'b1;
                            txd_out_p <= bit_q;
                            txd_out_n <= ~bit_q;
                        end else if (data_enable) begin
                            phase     <= 1'b0;
                            bit_q     <= txd_in;
                            txd_out_p <= ~txd_in;
                            txd_out_n <= txd_in;
                        end else begin
                            state     <= ST_ETD;
                            etd_cnt   <= '0;
                            txd_out_p <= 1'b1;
                            txd_out_n <= 1'b0;
                        end
                    end
                end
                ST_ETD: begin
                    if (etd_cnt == EW'(ETD_CYCLES - 1)) begin
                        state     <= ST_SILENCE;
                        sil_cnt   <= '0;
                        txd_out_p <= 1'b0;
                    end else begin
                        etd_cnt <= etd_cnt + 1'b1;
                    end
                end
                ST_SILENCE: begin
                    nlp_cnt <= nlp_fire ? '0 : nlp_cnt + 1'b1;
                    if (nlp_fire) begin
                        nlp_pend <= 1'b1;
                    end
                    if (sil_cnt == SW'(SILENCE_CYCLES - 1)) begin
                        state  <= ST_IDLE;
                        txbusy <= 1'b0;
                    end else begin
                        sil_cnt <= sil_cnt + 1'b1;
                    end
                end
                ST_JAB: begin
                    if (data_enable) begin
                        quiet_cnt <= '0;
                    end else if (quiet_cnt == UW'(UNJAB_CYCLES - 1)) begin
                        state   <= ST_SILENCE;
                        sil_cnt <= '0;
                        jabber  <= 1'b0;
                    end else begin
                        quiet_cnt <= quiet_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    pls_link_mon #(
        .LP_MIN_GAP       (LP_MIN_GAP),
        .LP_MAX_GAP       (LP_MAX_GAP),
        .LINK_PULSES      (LINK_PULSES),
        .LINK_FAIL_CYCLES (LINK_FAIL_CYCLES)
    ) u_link_mon (
        .clk_20mhz (clk_20mhz),
        .rst_i     (rst_i),
        .rxd_in_p  (rxd_in_p),
        .rxd_in_n  (rxd_in_n),
        .rxd_out   (rxd_out),
        .link_ok   (link_ok)
    );

endmodule

// File: tb/tb_pls_gen2.sv
// tb/tb_pls_gen2.sv - self-checking bench for pls_gen2 with scaled timing parameters
module tb_pls_gen2;

    localparam int N      = 200;
    localparam int LPW    = 2;
    localparam int ETD    = 12;
    localparam int SIL    = 48;
    localparam int JABC   = 300;
    localparam int UNJ    = 50;
    localparam int MINGAP = 100;
    localparam int MAXGAP = 400;
    localparam int LPN    = 3;
    localparam int FAILC  = 1000;

    logic clk_20mhz = 1'b0;
    logic rst_i = 1'b1;
    logic data_enable = 1'b0, txd_in = 1'b0, nlp_en = 1'b0;
    logic rxd_in_p = 1'b0, rxd_in_n = 1'b0;
    logic rxd_out, txd_out_p, txd_out_n, txbusy, jabber, link_ok;

    always #25 clk_20mhz = ~clk_20mhz;

    pls_gen2 #(
        .NLP_INTERVAL(N), .LP_WIDTH(LPW), .ETD_CYCLES(ETD), .SILENCE_CYCLES(SIL),
        .JABBER_CYCLES(JABC), .UNJAB_CYCLES(UNJ), .LP_MIN_GAP(MINGAP), .LP_MAX_GAP(MAXGAP),
        .LINK_PULSES(LPN), .LINK_FAIL_CYCLES(FAILC)
    ) dut (
        .clk_20mhz(clk_20mhz), .rst_i(rst_i), .data_enable(data_enable), .txd_in(txd_in),
        .nlp_en(nlp_en), .rxd_in_p(rxd_in_p), .rxd_in_n(rxd_in_n), .rxd_out(rxd_out),
        .txd_out_p(txd_out_p), .txd_out_n(txd_out_n), .txbusy(txbusy), .jabber(jabber),
        .link_ok(link_ok)
    );

    typedef struct {
        bit rst, de, txd;
        bit ep, en, eb, ej;
    } vec_t;

    vec_t       tbl[$];
    logic [1:0] wave[$];
    int         n_vec = 0;
    int         n_bad = 0;
    int         cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_20mhz);
        #1;
        cyc++;
    endtask

    task automatic push(input bit r, input bit d, input bit t, input bit p, input bit n,
                        input bit b, input bit j);
        tbl.push_back('{r, d, t, p, n, b, j});
    endtask

    task automatic run_tbl(input string tag);
        foreach (tbl[i]) begin
            rst_i       = tbl[i].rst;
            data_enable = tbl[i].de;
            txd_in      = tbl[i].txd;
            step();
            chk({tag, ".p"}, txd_out_p, tbl[i].ep);
            chk({tag, ".n"}, txd_out_n, tbl[i].en);
            chk({tag, ".busy"}, txbusy, tbl[i].eb);
            chk({tag, ".jabber"}, jabber, tbl[i].ej);
        end
        tbl.delete();
    endtask

    // Frame rule: each bit is (!b,b) then (b,!b), then ETD high, then silence, then idle
    task automatic add_frame(input int nbits);
        bit b;
        for (int i = 0; i < nbits; i++) begin
            b = 1'($urandom_range(0, 1));
            push(0, 1, b, !b, b, 1, 0);
            push(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), b, !b, 1, 0);
        end
        for (int i = 0; i < ETD; i++) push(0, 0, 0, 1, 0, 1, 0);
        for (int i = 0; i < SIL; i++)
            push(0, (i > 0) ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)), 0, 0, 1, 0);
        for (int i = 0; i < int'($urandom_range(1, 4)); i++) push(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic add_pulse(input int gap);
        wave.push_back(2'b10);
        wave.push_back(2'b10);
        for (int i = 2; i < gap; i++) wave.push_back(2'b00);
    endtask

    task automatic add_burst(input int len);
        for (int i = 0; i < len; i++) wave.push_back((i % 2 == 0) ? 2'b10 : 2'b01);
    endtask

    task automatic add_idle(input int len);
        for (int i = 0; i < len; i++) wave.push_back(2'b00);
    endtask

    initial begin
        int  s, rel, last_rise, pcnt, g;
        bit  have_last, ok, exp_rx, prev_rx, exp_p;
        logic [1:0] w;

        // Reset, a 1/0/1 frame with a phase-1 enable glitch, ETD, silence, then a mid-frame reset
        push(1, 0, 0, 0, 0, 0, 0);
        push(1, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) push(0, 0, 0, 0, 0, 0, 0);
        push(0, 1, 1, 0, 1, 1, 0);
        push(0, 1, 1, 1, 0, 1, 0);
        push(0, 1, 0, 1, 0, 1, 0);
        push(0, 0, 1, 0, 1, 1, 0);
        push(0, 1, 1, 0, 1, 1, 0);
        push(0, 0, 0, 1, 0, 1, 0);
        for (int i = 0; i < ETD; i++) push(0, 0, 0, 1, 0, 1, 0);
        for (int i = 0; i < SIL; i++) push(0, (i > 0) && (i % 3 == 1), 1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) push(0, 0, 0, 0, 0, 0, 0);
        push(0, 1, 0, 1, 0, 1, 0);
        push(0, 1, 0, 0, 1, 1, 0);
        push(1, 1, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0, 0);
        run_tbl("tbl");
        chk("rst.link_ok", link_ok, 0);
        chk("rst.rxd_out", rxd_out, 0);

        // NLP cadence from reset release: pulses start every N cycles, LPW wide
        rst_i = 1'b1;
        step();
        rst_i  = 1'b0;
        nlp_en = 1'b1;
        cyc    = 0;
        for (int c = 1; c <= 3 * N; c++) begin
            step();
            exp_p = (c >= N) && ((c % N) < LPW);
            chk("nlp.p", txd_out_p, exp_p);
            chk("nlp.n", txd_out_n, 0);
        end
        // Enable during the first pulse cycle aborts it and starts a one-bit frame
        data_enable = 1'b1;
        txd_in      = 1'b1;
        step();
        chk("abort.p", txd_out_p, 0);
        chk("abort.n", txd_out_n, 1);
        chk("abort.busy", txbusy, 1);
        txd_in = 1'b0;
        step();
        chk("abort.ph1", {txd_out_p, txd_out_n}, 2'b10);
        data_enable = 1'b0;
        for (int i = 0; i < ETD; i++) begin
            step();
            chk("abort.etd", {txd_out_p, txd_out_n}, 2'b10);
        end
        // NLP timer restarted: next pulse N cycles after silence begins
        s = cyc + 1;
        for (int c = s; c <= s + 2 * N + 1; c++) begin
            step();
            rel   = c - s;
            exp_p = (rel >= N) && ((rel % N) < LPW);
            chk("renlp.p", txd_out_p, exp_p);
            chk("renlp.n", txd_out_n, 0);
            chk("renlp.busy", txbusy, rel < SIL);
        end
        nlp_en = 1'b0;

        // Jabber: enable held past JABC cycles, then quiet-count with one restart
        data_enable = 1'b1;
        for (int k = 0; k < JABC + 10; k++) begin
            txd_in = 1'($urandom_range(0, 1));
            step();
            chk("jab.busy", txbusy, 1);
            chk("jab.jabber", jabber, k >= JABC);
            if (k < JABC) chk("jab.line_diff", txd_out_p ^ txd_out_n, 1);
            else chk("jab.line", {txd_out_p, txd_out_n}, 2'b00);
        end
        data_enable = 1'b0;
        for (int k = 0; k < 20; k++) step();
        data_enable = 1'b1;
        step();
        chk("jab.held", jabber, 1);
        data_enable = 1'b0;
        for (int k = 0; k < UNJ + SIL + 2; k++) begin
            step();
            chk("unjab.jabber", jabber, k < UNJ - 1);
            chk("unjab.busy", txbusy, k < UNJ - 1 + SIL);
            chk("unjab.line", {txd_out_p, txd_out_n}, 2'b00);
        end

        // Random frames against the frame rule
        for (int f = 0; f < 25; f++) add_frame(int'($urandom_range(1, 8)));
        run_tbl("frame");

        // Link monitor: wire pattern built from gaps, checked against an event-time model
        add_idle(10);
        for (int i = 0; i < 4; i++) add_pulse(200);
        add_pulse(60);
        add_burst(20);
        add_idle(130);
        add_pulse(MINGAP - 1);
        add_pulse(MINGAP);
        add_pulse(MAXGAP);
        add_pulse(MAXGAP + 1);
        add_pulse(200);
        for (int i = 0; i < 14; i++) begin
            case ($urandom_range(0, 2))
                0:       add_pulse(int'($urandom_range(3, MINGAP - 1)));
                1:       add_pulse(int'($urandom_range(MINGAP, MAXGAP)));
                default: add_pulse(int'($urandom_range(MAXGAP + 1, FAILC - 1)));
            endcase
        end
        add_pulse(FAILC + 20);
        have_last = 1'b0;
        ok        = 1'b0;
        pcnt      = 0;
        last_rise = 0;
        prev_rx   = 1'b0;
        for (int c = 0; c < wave.size() + 3; c++) begin
            w        = (c < wave.size()) ? wave[c] : 2'b00;
            rxd_in_p = w[1];
            rxd_in_n = w[0];
            step();
            exp_rx = (c >= 2) ? (wave[c-2][1] & ~wave[c-2][0]) : 1'b0;
            if (exp_rx && !prev_rx) begin
                if (have_last) begin
                    g = c - last_rise;
                    if (g >= MINGAP && g <= MAXGAP) begin
                        pcnt = (pcnt < LPN) ? pcnt + 1 : LPN;
                        if (pcnt == LPN) ok = 1'b1;
                    end else if (g > MAXGAP) begin
                        pcnt = 1;
                    end
                end
                have_last = 1'b1;
                last_rise = c;
            end else if (have_last && (c - last_rise == FAILC)) begin
                ok        = 1'b0;
                pcnt      = 0;
                have_last = 1'b0;
            end
            prev_rx = exp_rx;
            chk("rx.rxd_out", rxd_out, exp_rx);
            chk("rx.link_ok", link_ok, ok);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pls_gen2.md
Name: pls_gen2

Overview:
- Second-generation 10BASE-T physical layer signalling block. Sits between the MAC serialiser and the twisted-pair line drivers/receivers.
- Transmit path: Manchester encoding, end-of-transmission delimiter (ETD), mandatory silence, normal link pulse (NLP) generation and jabber protection.
- Receive path: synchronises the receive pair and runs a link-integrity monitor that drives link_ok.
- All timings are parameters in clk_20mhz cycles, one cycle per 50 ns half-bit.

Parameters:
NLP_INTERVAL, 320000, cycles between NLP starts (16 ms)
LP_WIDTH, 2, NLP high width in cycles
ETD_CYCLES, 12, cycles of TP_IDL high after last bit
SILENCE_CYCLES, 48, forced-low cycles after ETD
JABBER_CYCLES, 400000, max continuous DATA cycles before jabber (20 ms)
UNJAB_CYCLES, 10000, quiet cycles needed to leave jabber
LP_MIN_GAP, 80000, min rx edge gap counted as a valid link pulse (4 ms)
LP_MAX_GAP, 500000, max rx edge gap counted as a valid link pulse (25 ms)
LINK_PULSES, 3, consecutive valid pulses needed to set link_ok
LINK_FAIL_CYCLES, 2000000, no rx edge for this long clears link_ok (100 ms)

Ports:
clk_20mhz  in  1  20 MHz clock, single clock domain
rst_i  in  1  asynchronous active-high reset
data_enable  in  1  MAC transmit enable, held for both half-bit cycles of every bit
txd_in  in  1  MAC transmit bit, held for both half-bit cycles of every bit
nlp_en  in  1  when 0, NLP generation is suppressed
rxd_in_p  in  1  receive pair, positive leg
rxd_in_n  in  1  receive pair, negative leg
rxd_out  out  1  synchronised receive data (p & !n)
txd_out_p  out  1  line driver, positive leg
txd_out_n  out  1  line driver, negative leg
txbusy  out  1  high in every TX state except IDLE
jabber  out  1  high in the JAB state
link_ok  out  1  link integrity status

Behaviour:
- Reset: asynchronous on rst_i high.
  - Every output 0.
  - TX state IDLE; all counters 0; synchronisers 0.
  - Mid-operation reset drops the line to 0/0 immediately, with no ETD.
- Outputs: all are registered. Every line output changes one cycle after the state/input that causes it.
- TX FSM states: IDLE, DATA, ETD, SILENCE, JAB.
- IDLE:
  - n=0.
  - p=1 only during an NLP pulse, otherwise 0.
  - The NLP timer counts in IDLE and SILENCE.
  - When the timer reaches NLP_INTERVAL-1 in IDLE and nlp_en=1: emit LP_WIDTH cycles of p=1, then restart the timer at 0.
  - If the timer expires in SILENCE, the pulse is deferred to the first IDLE cycle.
  - If nlp_en=0 the timer still runs, but p stays 0.
  - data_enable=1 in IDLE (including mid-NLP): abort any pulse, capture txd_in, go to DATA at half-bit phase 0, clear the NLP and jabber counters.
- DATA:
  - Phase toggles every cycle.
  - Phase 0 output: p=!bit, n=bit.
  - Phase 1 output: p=bit, n=!bit, using the bit captured at phase 0 regardless of inputs.
  - At the start of each phase 0, data_enable is sampled:
    - 1: capture txd_in, continue.
    - 0: go to ETD.
  - data_enable dropping during phase 1 is ignored until the next phase 0.
  - The jabber counter increments every DATA cycle. Reaching JABBER_CYCLES-1 goes to JAB immediately, with no ETD.
- ETD: p=1, n=0 for ETD_CYCLES cycles, then SILENCE.
- SILENCE:
  - p=0, n=0 for SILENCE_CYCLES cycles, then IDLE.
  - data_enable is ignored.
- JAB:
  - p=0, n=0, jabber=1.
  - The quiet counter resets whenever data_enable=1.
  - After UNJAB_CYCLES consecutive cycles with data_enable=0, go to SILENCE.
- Line invariant: p and n are never both 1.
- RX datapath: two-flop synchroniser on rxd_in_p and rxd_in_n. rxd_out = sync_p & !sync_n, registered, 3-cycle latency.
- Link monitor:
  - A rising edge of rxd_out restarts the gap counter. The counter saturates and does not wrap.
  - Gap on an edge < LP_MIN_GAP: ignored (data activity); pulse count unchanged.
  - Gap in [LP_MIN_GAP, LP_MAX_GAP]: pulse count +1, saturating at LINK_PULSES. link_ok is set when the count reaches LINK_PULSES.
  - Gap > LP_MAX_GAP: pulse count restarts at 1.
  - Gap counter reaching LINK_FAIL_CYCLES: link_ok=0, count=0.
  - The first edge after reset or a fail only starts timing.
- Counter widths: $clog2(param+1) each, at most 32 bits.

Decomposition:
- Shared package pls_pkg:
  - TX state enum.
  - Default timing localparams (10BASE-T values above), so MAC-side blocks can reuse them.
- One sub-module, pls_link_mon: synchroniser, rxd_out and the link-integrity logic. The TX FSM stays in pls_gen2.

Test Plan:
- Reset then idle, nlp_en=1 -> first p pulse of 2 cycles starting 320000 cycles after reset release; n stays 0; next pulse 320000 cycles after the first one starts.
- Send bits 1,0 (each held 2 cycles), then drop data_enable -> p sequence 0,1,1,0, then 12 cycles p=1,n=0, then 48 cycles 0/0; txbusy low on the next cycle.
- data_enable asserted during NLP pulse cycle 1 -> pulse aborted; DATA encoding on the next cycle; NLP timer restarted.
- data_enable held 400000 cycles (JABBER_CYCLES=400000) -> jabber=1, line 0/0. Release; after 10000 quiet cycles go to SILENCE, then IDLE.
- Rx pulses at 16 ms spacing -> link_ok=1 after the 4th edge (first edge only starts timing). Then no rx edges -> link_ok=0 exactly 2000000 cycles after the last edge.
- Rx 10 MHz data burst between link pulses -> pulse count unchanged, link_ok stays as before.
